// File: rtl/cmi_timeslot_monitor.sv
// Receive-side checker for the CMI single-timeslot marker stream.
// Counts one-cycle marker pulses against an expected total and measures the
// marker-to-marker period against the programmed slot width (PER = width+2).
// Raises sticky flags for period errors, missing markers and surplus markers.
module cmi_timeslot_monitor #(
  parameter int CNT_W = 24,
  parameter int WID_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic [WID_W-1:0]   width,
  input  logic [CNT_W-1:0]   expect_count,
  input  logic               marker,
  output logic               busy,
  output logic               done,
  output logic               period_err,
  output logic               timeout,
  output logic               overrun,
  output logic [CNT_W-1:0]   rx_count,
  output logic [WID_W+1:0]   last_period
);

  // Period arithmetic width: 2*(2^WID_W - 1 + 2) always fits in WID_W+2 bits.
  localparam int PW = WID_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    TRACK,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WID_W-1:0]  w_q;
  logic [CNT_W-1:0]  n_q;
  logic [PW-1:0]     gap_q, gap_d;

  logic [CNT_W-1:0]  rx_d;
  logic [PW-1:0]     lp_d;
  logic              pe_d, to_d, ov_d, done_d;

  logic [PW-1:0]     per, lim, lim_m1, gap_inc;
  logic [CNT_W-1:0]  rx_inc;

  // Expected period and timeout limit derived from the width latched at arm.
  assign per     = PW'(w_q) + PW'(2);
  assign lim     = per << 1;
  assign lim_m1  = lim - PW'(1);

  // Free-running gap counter step, parked at the timeout limit.
  assign gap_inc = (gap_q >= lim) ? lim : gap_q + PW'(1);

  // Marker count step, parked at all-ones.
  assign rx_inc  = (rx_count == {CNT_W{1'b1}}) ? rx_count : rx_count + CNT_W'(1);

  // Only the two active states report busy; derived straight from the state register.
  assign busy    = (state_q == WAIT_FIRST) || (state_q == TRACK);

  // Next-state and next-status logic; arm overrides every state.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state_q;
    gap_d   = gap_inc;
    rx_d    = rx_count;
    lp_d    = last_period;
    pe_d    = period_err;
    to_d    = timeout;
    ov_d    = overrun;
    done_d  = 1'b0;

    if (arm) begin
      gap_d   = '0;
      rx_d    = '0;
      lp_d    = '0;
      pe_d    = 1'b0;
      to_d    = 1'b0;
      ov_d    = 1'b0;
      if (expect_count == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = WAIT_FIRST;
      end
    end else begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (marker) begin
            rx_d  = CNT_W'(1);
            gap_d = PW'(1);
            if (n_q == CNT_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = TRACK;
            end
          end else if (gap_q == lim_m1) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
        TRACK: begin
          if (marker) begin
            lp_d  = gap_q;
            if (gap_q != per) pe_d = 1'b1;
            rx_d  = rx_inc;
            gap_d = PW'(1);
            if (rx_inc == n_q) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else if (gap_q == lim_m1) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          if (marker) begin
            ov_d  = 1'b1;
            rx_d  = rx_inc;
            gap_d = PW'(1);
          end
        end
        default: ;  // IDLE: markers ignored, wait for arm
      endcase
    end
  end

  // State, counters and registered status outputs.
  // NOTE: the reset is asynchronous, so rst sits in the sensitivity list alongside clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      n_q         <= '0;
      gap_q       <= '0;
      rx_count    <= '0;
      last_period <= '0;
      period_err  <= 1'b0;
      timeout     <= 1'b0;
      overrun     <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees pre-edge values.
      state_q     <= state_d;
      gap_q       <= gap_d;
      rx_count    <= rx_d;
      last_period <= lp_d;
      period_err  <= pe_d;
      timeout     <= to_d;
      overrun     <= ov_d;
      done        <= done_d;
      if (arm) begin
        w_q <= width;
        n_q <= expect_count;
      end
    end
  end

endmodule
